// File: rtl/xorshift_bank.sv
// xorshift_bank: NUM_CH parallel xorshift128 generators sharing one seed.
// Each channel decorrelates the shared seed by XORing all four words with
// (channel * SEED_STRIDE). A WARM phase discards WARMUP advances after every
// reset or seed load; the RUN phase presents words with a valid/ready handshake.
// Optional macro XORSHIFT_ZERO_GUARD_EN: a channel whose seeded state would be
// all zero loads the default seed for that channel instead.
module xorshift_bank #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned WARMUP      = 8,
  parameter logic [31:0] SEED_STRIDE = 32'h9E3779B9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    seed_valid,
  input  logic [127:0]            seed_data,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [32*NUM_CH-1:0]    rand_num,
  output logic [31:0]             accept_cnt
);

  localparam logic [0:0]   WARM         = 1'b0;
  localparam logic [0:0]   RUN          = 1'b1;
  localparam logic [0:0]   LOAD_STATE   = (WARMUP == 0) ? RUN : WARM;
  localparam logic [7:0]   WARM_N       = 8'(WARMUP);
  localparam logic [127:0] DEFAULT_SEED = {32'd123456789, 32'd362436069,
                                           32'd521288629, 32'd88675123};

  // Per-channel state packed as {x,y,z,w}, x in the top word.
  logic [127:0] r_st [NUM_CH];
  logic [0:0]   r_state;
  logic [7:0]   r_warm_cnt;
  logic [31:0]  r_accept_cnt;

  logic         w_load;
  logic         w_advance;
  logic         w_accept;
  logic [127:0] w_seed_src;

  function automatic logic [127:0] xs_advance(input logic [127:0] s);
    logic [31:0] x, y, z, w, t, nw;
    x  = s[127:96];
    y  = s[95:64];
    z  = s[63:32];
    w  = s[31:0];
    t  = x ^ (x << 11);
    nw = (w ^ (w >> 19)) ^ (t ^ (t >> 8));
    return {y, z, w, nw};
  endfunction

  function automatic logic [127:0] chan_seed(input logic [127:0] s, input int unsigned ch);
    logic [31:0]  k;
    logic [127:0] r;
    k = ch * SEED_STRIDE;
    r = s ^ {4{k}};
`ifdef XORSHIFT_ZERO_GUARD_EN
    if (r == '0) r = DEFAULT_SEED ^ {4{k}};
`endif
    return r;
  endfunction

  // Load/advance decode; rst wins over seed_valid, and any load wins over an advance.
  always_comb begin
    w_load     = rst | seed_valid;
    w_seed_src = rst ? DEFAULT_SEED : seed_data;
    w_accept   = (r_state == RUN) & out_ready;
    w_advance  = (r_state == WARM) | w_accept;
  end

  // Channel state: seed on load, otherwise step all channels together when advancing.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (w_load)         r_st[i] <= chan_seed(w_seed_src, i);
      else if (w_advance) r_st[i] <= xs_advance(r_st[i]);
    end
  end

  // Phase control, warm-up counting and accepted-transfer count.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_state      <= LOAD_STATE;
      r_warm_cnt   <= '0;
      r_accept_cnt <= '0;
    end else if (r_state == WARM) begin
      r_warm_cnt <= r_warm_cnt + 8'd1;
      if (r_warm_cnt + 8'd1 == WARM_N) r_state <= RUN;
    end else if (w_accept) begin
      r_accept_cnt <= r_accept_cnt + 32'd1;
    end
  end

  // Outputs come straight from the registers.
  always_comb begin
    out_valid  = (r_state == RUN);
    accept_cnt = r_accept_cnt;
    rand_num   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) rand_num[32*i +: 32] = r_st[i][31:0];
  end

endmodule

// File: tb/tb_xorshift_bank.sv
// Bench for xorshift_bank: a default instance (4 channels, WARMUP=8) and a
// WARMUP=0 two-channel instance share clock, reset and seed inputs; each has
// its own ready. A sequence-level reference model predicts every output.
module tb_xorshift_bank;
  localparam int NCH  = 4;
  localparam int WU   = 8;
  localparam int N0CH = 2;
  localparam logic [31:0] STRIDE = 32'h9E3779B9;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                seed_valid = 1'b0;
  logic [127:0]        seed_data = '0;
  logic                out_ready = 1'b0;
  logic                rdy0 = 1'b0;
  logic                out_valid, out_valid0;
  logic [32*NCH-1:0]   rand_num;
  logic [32*N0CH-1:0]  rand_num0;
  logic [31:0]         accept_cnt, accept_cnt0;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: each channel is the last four words of its sequence,
  // index 0 oldest (x) .. 3 newest (w); out words are the newest element.
  logic [31:0] m  [NCH][4];
  logic [31:0] m0 [N0CH][4];
  int          m_warm_left;
  logic [31:0] m_acc, m0_acc;

  xorshift_bank #(.NUM_CH(NCH), .WARMUP(WU), .SEED_STRIDE(STRIDE)) dut (
    .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed_data(seed_data),
    .out_ready(out_ready), .out_valid(out_valid), .rand_num(rand_num),
    .accept_cnt(accept_cnt));

  xorshift_bank #(.NUM_CH(N0CH), .WARMUP(0), .SEED_STRIDE(STRIDE)) dut0 (
    .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed_data(seed_data),
    .out_ready(rdy0), .out_valid(out_valid0), .rand_num(rand_num0),
    .accept_cnt(accept_cnt0));

  always #5 clk = ~clk;

  function automatic logic [31:0] nxt(input logic [31:0] oldest, input logic [31:0] newest);
    logic [31:0] t;
    t = oldest ^ (oldest << 11);
    return (newest ^ (newest >> 19)) ^ (t ^ (t >> 8));
  endfunction

  function automatic logic [127:0] seeded(input logic [127:0] s, input int ch);
    logic [31:0]  k;
    logic [127:0] r;
    k = 32'(ch) * STRIDE;
    r = s ^ {k, k, k, k};
`ifdef XORSHIFT_ZERO_GUARD_EN
    if (r == 128'd0)
      r = {32'd123456789 ^ k, 32'd362436069 ^ k, 32'd521288629 ^ k, 32'd88675123 ^ k};
`endif
    return r;
  endfunction

  // Advance the model by one clock using the inputs currently applied, then wait the edge.
  task automatic tick();
    logic [127:0] src, s;
    logic [31:0]  nw;
    if (rst || seed_valid) begin
      src = rst ? {32'd123456789, 32'd362436069, 32'd521288629, 32'd88675123} : seed_data;
      for (int c = 0; c < NCH; c++) begin
        s = seeded(src, c);
        m[c][0] = s[127:96]; m[c][1] = s[95:64]; m[c][2] = s[63:32]; m[c][3] = s[31:0];
      end
      for (int c = 0; c < N0CH; c++) begin
        s = seeded(src, c);
        m0[c][0] = s[127:96]; m0[c][1] = s[95:64]; m0[c][2] = s[63:32]; m0[c][3] = s[31:0];
      end
      m_warm_left = WU;
      m_acc  = '0;
      m0_acc = '0;
    end else begin
      if (m_warm_left > 0 || out_ready) begin
        for (int c = 0; c < NCH; c++) begin
          nw = nxt(m[c][0], m[c][3]);
          m[c][0] = m[c][1]; m[c][1] = m[c][2]; m[c][2] = m[c][3]; m[c][3] = nw;
        end
        if (m_warm_left > 0) m_warm_left--;
        else m_acc++;
      end
      if (rdy0) begin
        for (int c = 0; c < N0CH; c++) begin
          nw = nxt(m0[c][0], m0[c][3]);
          m0[c][0] = m0[c][1]; m0[c][1] = m0[c][2]; m0[c][2] = m0[c][3]; m0[c][3] = nw;
        end
        m0_acc++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; seed_valid = 1'b0; out_ready = 1'b0; rdy0 = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] k;
    do_reset();
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_tests++;
    if (accept_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_acc got %0d want 0", accept_cnt); end
    n_tests++;
    if (out_valid0 !== 1'b1) begin n_fail++; $display("FAIL reset_valid_w0 got %b want 1", out_valid0); end
    for (int c = 0; c < NCH; c++) begin
      k = 32'(c) * STRIDE;
      n_tests++;
      if (rand_num[32*c +: 32] !== (32'd88675123 ^ k)) begin
        n_fail++;
        $display("FAIL reset_word ch%0d got %h want %h", c, rand_num[32*c +: 32], 32'd88675123 ^ k);
      end
    end
  endtask

  task automatic test_warmup0();
    do_reset();
    n_tests++;
    if (rand_num0[31:0] !== 32'd88675123) begin n_fail++; $display("FAIL w0_first got %0d want 88675123", rand_num0[31:0]); end
    n_tests++;
    if (rand_num0[63:32] !== (32'd88675123 ^ STRIDE)) begin n_fail++; $display("FAIL w0_ch1 got %h want %h", rand_num0[63:32], 32'd88675123 ^ STRIDE); end
    rdy0 = 1'b1;
    tick();
    rdy0 = 1'b0;
    n_tests++;
    if (rand_num0[31:0] !== 32'd3701687786) begin n_fail++; $display("FAIL w0_second got %0d want 3701687786", rand_num0[31:0]); end
    n_tests++;
    if (accept_cnt0 !== 32'd1) begin n_fail++; $display("FAIL w0_acc got %0d want 1", accept_cnt0); end
  endtask

  // Counts cycles with out_valid low after a load; bounded.
  task automatic count_low(output int low);
    low = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) break;
      low++;
      tick();
    end
  endtask

  task automatic test_warmup();
    logic [31:0] seq [12];
    int low;
    seq[0] = 32'd123456789; seq[1] = 32'd362436069; seq[2] = 32'd521288629; seq[3] = 32'd88675123;
    for (int n = 4; n < 12; n++) seq[n] = nxt(seq[n-4], seq[n-1]);
    do_reset();
    count_low(low);
    n_tests++;
    if (low != WU) begin n_fail++; $display("FAIL warm_len got %0d want %0d", low, WU); end
    n_tests++;
    if (rand_num[31:0] !== seq[11]) begin n_fail++; $display("FAIL warm_ninth got %0d want %0d", rand_num[31:0], seq[11]); end
  endtask

  task automatic test_stall();
    logic [32*NCH-1:0] snap;
    logic [31:0]       acc_snap;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    out_ready = 1'b0;
    for (int c = 0; c < NCH; c++) snap[32*c +: 32] = m[c][3];
    acc_snap = m_acc;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || rand_num !== snap || accept_cnt !== acc_snap) begin
        n_fail++;
        $display("FAIL stall cyc%0d valid=%b acc=%0d want 1/%0d word0 got %h want %h",
                 i, out_valid, accept_cnt, acc_snap, rand_num[31:0], snap[31:0]);
      end
    end
  endtask

  task automatic test_random();
    logic [32*NCH-1:0]  exp;
    logic [32*N0CH-1:0] exp0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      out_ready  = 1'($urandom_range(0, 1));
      rdy0       = 1'($urandom_range(0, 1));
      seed_valid = ($urandom_range(0, 59) == 0);
      seed_data  = {$urandom, $urandom, $urandom, $urandom};
      tick();
      for (int c = 0; c < NCH; c++) exp[32*c +: 32] = m[c][3];
      for (int c = 0; c < N0CH; c++) exp0[32*c +: 32] = m0[c][3];
      n_tests++;
      if (out_valid !== (m_warm_left == 0) || rand_num !== exp || accept_cnt !== m_acc) begin
        n_fail++;
        $display("FAIL random cyc%0d valid=%b acc=%0d word0=%h want %b/%0d/%h",
                 i, out_valid, accept_cnt, rand_num[31:0], m_warm_left == 0, m_acc, exp[31:0]);
      end
      n_tests++;
      if (out_valid0 !== 1'b1 || rand_num0 !== exp0 || accept_cnt0 !== m0_acc) begin
        n_fail++;
        $display("FAIL random_w0 cyc%0d valid=%b acc=%0d nums=%h want 1/%0d/%h",
                 i, out_valid0, accept_cnt0, rand_num0, m0_acc, exp0);
      end
    end
    seed_valid = 1'b0; out_ready = 1'b0; rdy0 = 1'b0;
  endtask

  task automatic test_distinct();
    int dup;
    logic [31:0] a, b;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 1000 + WU; i++) begin
      tick();
      dup = 0;
      for (int p = 0; p < NCH; p++)
        for (int q = p + 1; q < NCH; q++) begin
          a = rand_num[32*p +: 32];
          b = rand_num[32*q +: 32];
          if (a == b) dup++;
        end
      n_tests++;
      if (dup != 0 || rand_num[31:0] !== m[0][3]) begin
        n_fail++;
        $display("FAIL distinct cyc%0d dups=%0d word0 got %h want %h", i, dup, rand_num[31:0], m[0][3]);
      end
    end
    n_tests++;
    if (accept_cnt !== 32'd1000) begin n_fail++; $display("FAIL distinct_acc got %0d want 1000", accept_cnt); end
    out_ready = 1'b0;
  endtask

  task automatic test_seed();
    int low;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    seed_valid = 1'b1;
    seed_data  = {$urandom, $urandom, $urandom, $urandom};
    tick();
    seed_valid = 1'b0;
    n_tests++;
    if (accept_cnt !== 32'd0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL seed_accept acc=%0d valid=%b want 0/0", accept_cnt, out_valid);
    end
    n_tests++;
    if (rand_num[95:64] !== m[2][3]) begin n_fail++; $display("FAIL seed_word ch2 got %h want %h", rand_num[95:64], m[2][3]); end
    for (int i = 0; i < 3; i++) tick();
    seed_valid = 1'b1;
    seed_data  = {$urandom, $urandom, $urandom, $urandom};
    tick();
    seed_valid = 1'b0;
    count_low(low);
    n_tests++;
    if (low != WU) begin n_fail++; $display("FAIL seed_rewarm got %0d want %0d", low, WU); end
    n_tests++;
    if (rand_num[127:96] !== m[3][3]) begin n_fail++; $display("FAIL seed_rewarm_word got %h want %h", rand_num[127:96], m[3][3]); end
    out_ready = 1'b0;
  endtask

  task automatic test_zero_seed();
    logic [31:0] want0;
`ifdef XORSHIFT_ZERO_GUARD_EN
    want0 = 32'd88675123;
`else
    want0 = 32'd0;
`endif
    out_ready = 1'b1;
    tick();
    seed_valid = 1'b1;
    seed_data  = '0;
    tick();
    seed_valid = 1'b0;
    n_tests++;
    if (rand_num[31:0] !== want0 || accept_cnt !== 32'd0) begin
      n_fail++; $display("FAIL zero_seed word0=%h acc=%0d want %h/0", rand_num[31:0], accept_cnt, want0);
    end
    for (int i = 0; i < WU + 10; i++) begin
      tick();
      n_tests++;
      if (rand_num[31:0] !== m[0][3] || rand_num[63:32] !== m[1][3]) begin
        n_fail++;
        $display("FAIL zero_run cyc%0d got %h %h want %h %h", i, rand_num[31:0], rand_num[63:32], m[0][3], m[1][3]);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_rst_override();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1; seed_valid = 1'b1; seed_data = {$urandom, $urandom, $urandom, $urandom}; rdy0 = 1'b1;
    tick();
    rst = 1'b0; seed_valid = 1'b0; out_ready = 1'b0; rdy0 = 1'b0;
    n_tests++;
    if (rand_num[31:0] !== 32'd88675123 || out_valid !== 1'b0 || accept_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_override word0=%h valid=%b acc=%0d want %h/0/0", rand_num[31:0], out_valid, accept_cnt, 32'd88675123);
    end
    n_tests++;
    if (rand_num0[31:0] !== 32'd88675123 || accept_cnt0 !== 32'd0) begin
      n_fail++; $display("FAIL rst_override_w0 word0=%h acc=%0d want %h/0", rand_num0[31:0], accept_cnt0, 32'd88675123);
    end
  endtask

  initial begin
    m_warm_left = WU; m_acc = '0; m0_acc = '0;
    test_reset();
    test_warmup0();
    test_warmup();
    test_stall();
    test_random();
    test_distinct();
    test_seed();
    test_zero_seed();
    test_rst_override();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/xorshift_bank.md
XORSHIFT_BANK -- requirements
Module: xorshift_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent xorshift128 channels (1..16).
REQ-002 SHALL have parameter WARMUP, default 8, number of discarded advances after reset or seed load (0..255).
REQ-003 SHALL have parameter SEED_STRIDE, default 32'h9E3779B9, per-channel seed decorrelation constant.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port seed_valid  input  1  load seed_data into all channels this cycle.
REQ-007 SHALL have port seed_data  input  128  seed words {x,y,z,w}, x in bits [127:96].
REQ-008 SHALL have port out_ready  input  1  consumer accepts rand_num this cycle.
REQ-009 SHALL have port out_valid  output  1  rand_num holds a deliverable value.
REQ-010 SHALL have port rand_num  output  32*NUM_CH  channel i word in bits [32*i+31:32*i].
REQ-011 SHALL have port accept_cnt  output  32  accepted-transfer count.

Function
REQ-012 SHALL hold per channel 32-bit state x,y,z,w; rand_num word i equals channel i w, combinational from the register.
REQ-013 An advance SHALL be: x<=y, y<=z, z<=w, w<=(w^(w>>19))^(t^(t>>8)), t=x^(x<<11), all 32-bit, shifts zero-filling.
REQ-014 Channel i seeding SHALL XOR each of the four seed words with (i*SEED_STRIDE) mod 2^32; channel 0 receives the seed unmodified.
REQ-015 FSM SHALL have states WARM and RUN.
REQ-016 In WARM, all channels SHALL advance every cycle, out_valid=0, warm-up counter increments; on the cycle reaching WARMUP advances the state SHALL enter RUN.
REQ-017 In RUN, out_valid=1; all channels SHALL advance exactly on cycles with out_valid & out_ready, else hold state unchanged.
REQ-018 accept_cnt SHALL increment by 1 on each out_valid & out_ready, wrapping 2^32-1 to 0.
REQ-019 seed_valid in any state SHALL load seeded state, clear warm-up counter and accept_cnt, enter WARM (RUN directly if WARMUP=0); out_valid=0 the following cycle when WARMUP>0.
REQ-020 seed_valid coincident with out_valid & out_ready SHALL take priority over the advance; that transfer counts as delivered but accept_cnt is still cleared.
REQ-021 seed_valid during WARM SHALL restart warm-up from the new seed.
REQ-022 out_valid SHALL never drop in RUN without rst or seed_valid; rand_num SHALL stay stable while out_valid & ~out_ready.

Reset
REQ-023 rst SHALL load default seed x=123456789, y=362436069, z=521288629, w=88675123 per REQ-014, clear warm-up counter and accept_cnt, enter WARM (RUN if WARMUP=0).
REQ-024 Outputs during and after the reset cycle: out_valid=0 (1 if WARMUP=0), accept_cnt=0, rand_num word i = 88675123^(i*SEED_STRIDE) until first advance.
REQ-025 rst SHALL override seed_valid and out_ready in the same cycle; rst mid-warm-up or mid-RUN aborts immediately.

Configuration
REQ-026 Macro XORSHIFT_ZERO_GUARD_EN defined: a channel whose post-XOR 128-bit seed is all zero SHALL load the REQ-023 default seed for that channel instead.
REQ-027 Macro undefined: all-zero seed SHALL be loaded as-is; that channel outputs 0 forever; no other behaviour differs.

Verification
REQ-028 WARMUP=0, rst then out_ready=1: channel 0 rand_num 88675123, then 3701687786 after first accept; accept_cnt 0 then 1.
REQ-029 WARMUP=8, rst released: out_valid low exactly 8 cycles, then high; channel 0 value equals the 9th element of the default sequence.
REQ-030 RUN with out_ready=0 for 20 cycles: rand_num and accept_cnt unchanged; out_valid stays 1.
REQ-031 seed_valid with seed_data=128'h0 coincident with accept: guard defined -> channel 0 restarts at 88675123 sequence; undefined -> channel 0 reads 0 permanently; accept_cnt=0.
REQ-032 NUM_CH=4, WARMUP=0, rst: channel 1 word = 88675123^32'h9E3779B9; channels produce mutually distinct words for 1000 accepts.
REQ-033 accept_cnt forced near wrap (1e6-accept soak, or rst/seed checks): increments monotonically, wraps to 0, clears on rst and seed_valid.
